// File: rtl/led_sequencer.sv
// LED pattern sequencer: two debounced buttons drive a run/pause FSM and a
// COUNT/SHIFT mode; the pattern advances once every WAIT_TIME cycles in RUN.
//   state | meaning
//   IDLE  | after reset, pattern and step timer held
//   RUN   | step timer counting, pattern advances on each wrap
//   PAUSE | step timer and pattern frozen, resume continues the count
module led_sequencer #(
  parameter int N_LEDS    = 3,
  parameter int WAIT_TIME = 13500000,
  parameter int DEBOUNCE  = 270000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bbutton,
  input  logic              mbutton,
  output logic [N_LEDS-1:0] led,
  output logic              running,
  output logic              mode
);

  localparam int TMR_W = $clog2(WAIT_TIME);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WAIT_TIME - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  // index 0 = bbutton, index 1 = mbutton
  logic [1:0]      sync1, sync2, deb, press;
  logic [DB_W-1:0] db_cnt [2];

  state_t              state, state_nxt;
  logic                mode_q, mode_nxt;
  logic [N_LEDS-1:0]   pattern, pattern_nxt, stepped;
  logic [TMR_W-1:0]    tmr, tmr_nxt;

  // Debounced levels reset low, so a button held through reset stays silent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {mbutton, bbutton};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= 1'b0;
      pattern <= '0;
      tmr     <= '0;
    end else begin
      state   <= state_nxt;
      mode_q  <= mode_nxt;
      pattern <= pattern_nxt;
      tmr     <= tmr_nxt;
    end
  end

  always_comb begin
    stepped = mode_q ? {pattern[N_LEDS-2:0], pattern[N_LEDS-1]}
                     : pattern + N_LEDS'(1);
  end

  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode_q;
    pattern_nxt = pattern;
    tmr_nxt     = tmr;
    case (state)
      IDLE: begin
        if (press[0]) state_nxt = RUN;
      end
      RUN: begin
        if (press[0]) state_nxt = PAUSE;
        if (tmr == TMR_LAST) begin
          tmr_nxt     = '0;
          pattern_nxt = stepped;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      PAUSE: begin
        if (press[0]) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
    // Mode reload overrides any step tick on the same edge.
    if (press[1]) begin
      mode_nxt    = ~mode_q;
      tmr_nxt     = '0;
      pattern_nxt = mode_q ? '0 : N_LEDS'(1);
    end
  end

  assign led     = ~pattern;
  assign running = (state == RUN);
  assign mode    = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: vector table, corner sequences and
// random button activity compared against a cycle-level behavioural model.
module tb_led_sequencer;

  localparam int N = 3;
  localparam int W = 4;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bbutton = 1'b1;
  logic         mbutton = 1'b1;
  logic [N-1:0] led;
  logic         running;
  logic         mode;

  led_sequencer #(.N_LEDS(N), .WAIT_TIME(W), .DEBOUNCE(D)) dut (
    .clk(clk), .rst_n(rst_n), .bbutton(bbutton), .mbutton(mbutton),
    .led(led), .running(running), .mode(mode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: pattern is derived from the number of RUN cycles since the last
  // reload, rather than from a step timer and an incrementing register.
  int         m_st;      // 0 idle, 1 run, 2 pause
  logic       m_mode;
  int         m_active;
  logic [1:0] m_d0, m_d1, m_deb, m_pend;
  int         m_streak [2];

  function automatic logic [N-1:0] m_pattern();
    int steps;
    logic [N-1:0] one;
    steps = m_active / W;
    one   = 1;
    if (m_mode) return one << (steps % N);
    return N'(steps % (1 << N));
  endfunction

  task automatic model_step();
    logic [1:0] samp;
    if (!rst_n) begin
      m_st = 0; m_mode = 1'b0; m_active = 0;
      m_d0 = '0; m_d1 = '0; m_deb = '0; m_pend = '0;
      m_streak[0] = 0; m_streak[1] = 0;
    end else begin
      if (m_st == 1) m_active++;
      if (m_pend[0]) m_st = (m_st == 1) ? 2 : 1;
      if (m_pend[1]) begin
        m_mode   = ~m_mode;
        m_active = 0;
      end
      samp   = m_d1;
      m_d1   = m_d0;
      m_d0   = {mbutton, bbutton};
      m_pend = '0;
      // A level is accepted after D consecutive samples that disagree with it.
      for (int i = 0; i < 2; i++) begin
        if (samp[i] == m_deb[i]) m_streak[i] = 0;
        else begin
          m_streak[i]++;
          if (m_streak[i] == D) begin
            m_deb[i]    = samp[i];
            m_streak[i] = 0;
            m_pend[i]   = ~samp[i];
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    logic [N-1:0] exp_led;
    @(posedge clk);
    model_step();
    #1;
    exp_led = ~m_pattern();
    check("model_led", led, exp_led);
    check("model_running", running, m_st == 1);
    check("model_mode", mode, m_mode);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    logic         rst;
    logic         b;
    logic         m;
    int           n;
    logic [N-1:0] led;
    logic         run;
    logic         mode;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int guard;

    vecs.push_back('{1'b0, 1'b1, 1'b1,  2, 3'b111, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 10, 3'b111, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1,  5, 3'b111, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1,  1, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1,  4, 3'b110, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1,  4, 3'b101, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1,  4, 3'b100, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1,  4, 3'b011, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16, 3'b111, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0,  5, 3'b110, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0,  1, 3'b110, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0,  4, 3'b101, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0,  4, 3'b011, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0,  4, 3'b110, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b1,  4, 3'b101, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0,  6, 3'b111, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst; bbutton = vecs[i].b; mbutton = vecs[i].m;
      ticks(vecs[i].n);
      check("vec_led", led, vecs[i].led);
      check("vec_running", running, vecs[i].run);
      check("vec_mode", mode, vecs[i].mode);
    end

    // Button held through reset stays silent until released and pressed.
    rst_n = 1'b0; bbutton = 1'b0; mbutton = 1'b1;
    ticks(2);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("held_reset_running", running, 1'b0);
    end
    bbutton = 1'b1; ticks(10);
    bbutton = 1'b0; ticks(5);
    check("rerelease_not_yet", running, 1'b0);
    tick();
    check("rerelease_running", running, 1'b1);

    // Pause mid-step, freeze, then resume with the leftover timer count.
    ticks(6);
    check("run6_led", led, 3'b110);
    bbutton = 1'b1; ticks(6);
    check("run12_led", led, 3'b100);
    bbutton = 1'b0; ticks(6);
    check("pause_running", running, 1'b0);
    check("pause_led", led, 3'b011);
    for (int k = 0; k < 40; k++) begin
      tick();
      check("frozen_led", led, 3'b011);
    end
    bbutton = 1'b1; ticks(6);
    bbutton = 1'b0; ticks(6);
    check("resume_running", running, 1'b1);
    check("resume_led", led, 3'b011);
    tick();
    check("resume_led_1", led, 3'b011);
    tick();
    check("resume_led_2", led, 3'b010);

    // One-cycle reset in RUN at pattern 5.
    rst_n = 1'b0; tick();
    check("midrun_rst_led", led, 3'b111);
    check("midrun_rst_running", running, 1'b0);
    check("midrun_rst_mode", mode, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("post_rst_running", running, 1'b0);
    end

    // Short glitch ignored; mode press landing on a step tick reloads.
    bbutton = 1'b1; ticks(8);
    bbutton = 1'b0; ticks(6);
    bbutton = 1'b1; ticks(8);
    bbutton = 1'b0; ticks(2);
    bbutton = 1'b1; ticks(10);
    check("glitch_running", running, 1'b1);
    guard = 0;
    while (m_active % W != 2 && guard < 8) begin
      tick();
      guard++;
    end
    check("align_guard_ok", guard < 8, 1'b1);
    mbutton = 1'b0; ticks(6);
    check("tick_reload_mode", mode, 1'b1);
    check("tick_reload_led", led, 3'b110);
    mbutton = 1'b1; ticks(8);

    // Random button activity with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) bbutton = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 6) == 0) mbutton = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
- REQ-001: Parameter N_LEDS, default 3, number of LED outputs; legal range is 2 to 16.
- REQ-002: Parameter WAIT_TIME, default 13500000, clock cycles per pattern step; minimum value is 2.
- REQ-003: Parameter DEBOUNCE, default 270000, clock cycles of stable input required before a debounced level change; minimum value is 1.
- REQ-004: clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-005: rst_n, input, 1, reset; synchronous, active-low.
- REQ-006: bbutton, input, 1, run/pause button; asynchronous, active-low (0 = pressed).
- REQ-007: mbutton, input, 1, mode button; asynchronous, active-low.
- REQ-008: led, output, N_LEDS, LED drive; active-low, led = ~pattern.
- REQ-009: running, output, 1, high exactly when the FSM is in RUN.
- REQ-010: mode, output, 1, 0 = COUNT, 1 = SHIFT.

Function
- REQ-011: Each button SHALL pass through a 2-flop synchronizer before any other logic.
- REQ-012: Each button SHALL have a debounced level, a stability counter, and the following update rules.
  - The counter clears whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE-1, the debounced level takes the synchronized value and the counter clears.
- REQ-013: A press event SHALL be a 1-to-0 transition of the debounced level, one cycle wide.
  - For a clean raw edge, the event is asserted at edge DEBOUNCE+2 after the raw change.
  - Its effect on state appears one edge later.
- REQ-014: Glitches shorter than DEBOUNCE cycles (post-sync) SHALL produce no event.
- REQ-015: The FSM SHALL have three states: IDLE, RUN, PAUSE.
  - On a bbutton event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - With no event, the state holds.
- REQ-016: In IDLE, pattern and step timer SHALL hold their reset values; the IDLE->RUN transition does not alter pattern.
- REQ-017: In RUN, the step timer SHALL count 0..WAIT_TIME-1.
  - At WAIT_TIME-1 it wraps to 0 and the pattern advances one step in the same edge.
  - Period is exactly WAIT_TIME cycles.
- REQ-018: In PAUSE, step timer and pattern SHALL hold; RUN resumes from the held timer value.
- REQ-019: COUNT step: pattern = pattern + 1 modulo 2^N_LEDS (all-ones wraps to 0).
- REQ-020: SHIFT step: rotate left by one (bit N_LEDS-1 moves to bit 0).
- REQ-021: An mbutton event in any state SHALL perform all of the following in the same edge.
  - Toggle mode.
  - Clear the step timer.
  - Load pattern = 0 when the new mode is COUNT, or pattern = 1 when it is SHIFT.
  - Leave the FSM state unchanged.
- REQ-022: If an mbutton event coincides with a step tick, the mode reload SHALL win and no advance occurs.
- REQ-023: Simultaneous bbutton and mbutton events SHALL both take effect in the same edge.
- REQ-024: The step timer width SHALL be $clog2(WAIT_TIME), and the debounce counter width $clog2(DEBOUNCE+1); no overflow is permitted.

Reset
- REQ-025: While rst_n = 0 at a clock edge, the block SHALL load the following values, overriding all other activity, including mid-RUN:
  - FSM to IDLE, mode = COUNT, pattern = 0, step timer = 0;
  - debounce counters = 0, synchronizers = 0;
  - debounced levels = 0 (treated as pressed).
- REQ-026: After reset the outputs SHALL be led = all ones, running = 0, mode = 0.
- REQ-027: Because debounced levels reset to 0, a button held through reset SHALL produce no event until it is released and pressed again.

Verification (N_LEDS=3, WAIT_TIME=4, DEBOUNCE=3)
- REQ-028: Reset, then bbutton released for 10 cycles and pressed (held) -> running rises exactly at edge 6 after the press; led steps 111->110->101->100 every 4 cycles; after 8 steps led returns to 111.
- REQ-029: bbutton held low through reset and for 20 cycles afterwards -> running stays 0; after release for 10 cycles then a press -> running = 1.
- REQ-030: In RUN, mbutton pressed -> mode = 1, led = 110 on the same edge, then 101, 011, 110 every 4 cycles; a second mbutton press -> mode = 0, led = 111.
- REQ-031: RUN, then a bbutton press -> running = 0 and led frozen for 40 cycles; another press -> stepping resumes, first step after the remaining timer count (not a full 4 cycles).
- REQ-032: A 2-cycle low glitch on bbutton, then a mbutton event aligned to a tick edge -> no FSM change from the glitch; pattern reloads, no advance.
- REQ-033: rst_n asserted for 1 cycle mid-RUN at pattern 5 -> next edge led = 111, running = 0, mode = 0; a subsequent press requires release first.
